psg_voice_sequencer: RTL

PSG_VOICE_SEQUENCER -- requirements
Module: psg_voice_sequencer

---
 rtl/psg_voice_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/psg_voice_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : psg_voice_sequencer
//  Description : Time-multiplexes one shared waveform generator / AND-mux
//                across four PSG voices. Each tick_i starts a 12-cycle round.
//                Each voice goes through ISSUE, SETTLE and CAPT. All four
//                results are published to out_o together when the round
//                completes.
//                Optional build macro PSG_VOICE_GATE_EN: a voice whose gate
//                bit (select register bit 5) is clear captures zero.
//  Revision    : 1.0  initial release
// ============================================================================
module psg_voice_sequencer #(
    parameter int WID = 12
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               tick_i,
    input  logic               we_i,
    input  logic [1:0]         adr_i,
    input  logic [5:0]         dat_i,
    output logic [1:0]         voice_o,
    output logic [4:0]         sel_o,
    input  logic [WID-1:0]     mux_i,
    output logic [4*WID-1:0]   out_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               ovr_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_CAPT   = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       r_cnt;
    logic [5:0]       r_sel [4];
    logic [1:0]       r_voice;
    logic [4:0]       r_sel_out;
    logic [4*WID-1:0] r_shadow;
    logic [4*WID-1:0] w_shadow_nxt;
    logic [4*WID-1:0] r_out;
    logic             r_ovr;
    logic [WID-1:0]   w_capt;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic: ticks outside IDLE are ignored here
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (tick_i) w_state_nxt = S_ISSUE;
            S_ISSUE:  w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = S_CAPT;
            S_CAPT:   w_state_nxt = (r_cnt == 2'd3) ? S_IDLE : S_ISSUE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: busy covers the whole round, done marks the final capture
    always_comb begin
        busy_o = (r_state != S_IDLE);
        done_o = (r_state == S_CAPT) && (r_cnt == 2'd3);
    end

`ifdef PSG_VOICE_GATE_EN
    // Gated voices capture zero; the select is still issued to the mux
    always_comb begin
        w_capt = r_sel[r_cnt][5] ? mux_i : '0;
    end
`else
    // Gate bit is kept in the register but has no effect on the capture
    logic w_gate_unused;
    always_comb begin
        w_capt        = mux_i;
        w_gate_unused = ^{r_sel[0][5], r_sel[1][5], r_sel[2][5], r_sel[3][5]};
    end
`endif

    // Shadow image after this cycle's capture; also the source for out_o
    // so the final slot reaches out_o on the same edge it is captured
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (r_state == S_CAPT) w_shadow_nxt[r_cnt*WID +: WID] = w_capt;
    end

    // Select registers are writable in every state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) r_sel[i] <= '0;
        end else if (we_i) begin
            r_sel[adr_i] <= dat_i;
        end
    end

    // Round datapath: voice counter, issued select, shadow and published results
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= 2'd0;
            r_voice   <= 2'd0;
            r_sel_out <= 5'd0;
            r_shadow  <= '0;
            r_out     <= '0;
        end else begin
            case (r_state)
                S_IDLE:  if (tick_i) r_cnt <= 2'd0;
                S_ISSUE: begin
                    r_voice   <= r_cnt;
                    r_sel_out <= r_sel[r_cnt][4:0];
                end
                S_CAPT: begin
                    r_shadow <= w_shadow_nxt;
                    if (r_cnt == 2'd3) r_out <= w_shadow_nxt;
                    else               r_cnt <= r_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Overrun pulse for a tick that lands inside a running round
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_ovr <= 1'b0;
        else         r_ovr <= tick_i && busy_o;
    end

    assign voice_o = r_voice;
    assign sel_o   = r_sel_out;
    assign out_o   = r_out;
    assign ovr_o   = r_ovr;

endmodule
`default_nettype wire
